// File: rtl/multi_tick_divider_pkg.sv
// Shared mode encodings and sizing helper for the multi-channel tick divider.
// Imported by the config interface, the channel counter and the top level.
package multi_tick_pkg;

  typedef enum logic [1:0] {
    MODE_PERIODIC = 2'b00,
    MODE_SQUARE   = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_RESERVED = 2'b11
  } mode_e;

  // Channel-select width; a single-channel build still needs a 1-bit select.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_tick_divider_if.sv
// Valid/ready configuration port of multi_tick_divider.
// The master drives a write request; the slave answers with ready and a reject pulse.
interface multi_tick_divider_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int CH_W = multi_tick_pkg::ch_w(NUM_CH);

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CH_W-1:0]       cfg_ch;
  logic [CNT_W-1:0]      cfg_div;
  multi_tick_pkg::mode_e cfg_mode;
  logic                  cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_mode,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_mode,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/multi_tick_divider_tick_channel.sv
// One divider channel: counter, active and shadow divisor/mode, pending flag,
// one-shot arm state and registered tick/wave/busy outputs.
module tick_channel
  import multi_tick_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  input  mode_e            wr_mode,
  output logic             tick,
  output logic             wave,
  output logic             busy,
  output logic             pending
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  mode_e            mode_q, mode_d;
  mode_e            sh_mode_q, sh_mode_d;
  logic             pending_q, pending_d;
  logic             done_q, done_d;
  logic             tick_q, tick_d;
  logic             wave_q, wave_d;
  logic             busy_q, busy_d;
  logic             term;

  assign term = (count_q == div_q - CNT_W'(1));

  always_comb begin
    count_d   = count_q;
    div_d     = div_q;
    mode_d    = mode_q;
    sh_div_d  = sh_div_q;
    sh_mode_d = sh_mode_q;
    pending_d = pending_q;
    done_d    = done_q;
    tick_d    = 1'b0;
    wave_d    = wave_q;
    busy_d    = busy_q;

    // Not counting this edge: writes land directly and any shadow is flushed in.
    if (!enable || sync || done_q) begin
      count_d = '0;
      wave_d  = 1'b0;
      busy_d  = enable && !done_q;
      if (!enable) begin
        done_d = 1'b0;
      end
      if (pending_q) begin
        div_d     = sh_div_q;
        mode_d    = sh_mode_q;
        pending_d = 1'b0;
      end
      if (wr_en) begin
        div_d  = wr_div;
        mode_d = wr_mode;
      end
    end else begin
      busy_d  = 1'b1;
      count_d = count_q + CNT_W'(1);
      if (term) begin
        count_d = '0;
        tick_d  = 1'b1;
        if (mode_q == MODE_SQUARE) begin
          wave_d = !wave_q;
        end
        if (mode_q == MODE_ONESHOT) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        if (pending_q) begin
          div_d     = sh_div_q;
          mode_d    = sh_mode_q;
          pending_d = 1'b0;
          if (sh_mode_q != MODE_SQUARE) begin
            wave_d = 1'b0;
          end
        end
      end
      // A write landing on a terminal edge waits for the next period boundary.
      if (wr_en) begin
        sh_div_d  = wr_div;
        sh_mode_d = wr_mode;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      div_q     <= CNT_W'(DEFAULT_DIV);
      mode_q    <= MODE_PERIODIC;
      sh_div_q  <= CNT_W'(DEFAULT_DIV);
      sh_mode_q <= MODE_PERIODIC;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
      wave_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      sh_div_q  <= sh_div_d;
      sh_mode_q <= sh_mode_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
      wave_q    <= wave_d;
      busy_q    <= busy_d;
    end
  end

  assign tick    = tick_q;
  assign wave    = wave_q;
  assign busy    = busy_q;
  assign pending = pending_q;

endmodule

// File: rtl/multi_tick_divider.sv
// Multi-channel programmable tick generator with a valid/ready config port.
// Define MULTI_TICK_SYNC_EN to add the sync_all input that phase-aligns every enabled channel.
module multi_tick_divider
  import multi_tick_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   enable,
`ifdef MULTI_TICK_SYNC_EN
  input  logic                sync_all,
`endif
  multi_tick_divider_if.slave cfg,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   wave,
  output logic [NUM_CH-1:0]   busy
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr_en;
  logic              sync_int;
  logic              ready;
  logic              xfer;
  logic              ch_bad;
  logic              div_zero;
  logic              cfg_err_q, cfg_err_d;

`ifdef MULTI_TICK_SYNC_EN
  assign sync_int = sync_all;
`else
  assign sync_int = 1'b0;
`endif

  // Out-of-range selects match no channel and so stay ready, letting the reject complete.
  always_comb begin
    ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        ready = !pending[i];
      end
    end
  end

  assign ch_bad    = (int'(cfg.cfg_ch) >= NUM_CH);
  assign div_zero  = (cfg.cfg_div == '0);
  assign xfer      = cfg.cfg_valid && ready;
  assign cfg_err_d = xfer && (ch_bad || div_zero);

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_en[i] = xfer && !div_zero && (cfg.cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg.cfg_ready = ready;
  assign cfg.cfg_err   = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable[g]),
      .sync    (sync_int),
      .wr_en   (wr_en[g]),
      .wr_div  (cfg.cfg_div),
      .wr_mode (cfg.cfg_mode),
      .tick    (tick[g]),
      .wave    (wave[g]),
      .busy    (busy[g]),
      .pending (pending[g])
    );
  end

endmodule
